// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the single-cycle 32-bit CPU.
//
// Holds the current fetch address and presents it to instruction memory every
// cycle. The next address is chosen from the control unit's PC-source select.
// A run/halt/fault state machine stops fetch on the halt opcode or on an
// illegal target. A retired-instruction counter counts completed fetch steps.
//
// Optional feature: define PC_BOUNDS_CHECK_EN to reject targets whose 4-byte
// fetch would run past IMEM_BYTES. Without it, only misalignment faults.
//
// Parameters:
//   RESET_PC    fetch address loaded on reset
//   IMEM_BYTES  instruction-memory size in bytes (bounds check only)
//   HALT_OP     opcode that stops fetch
//
// Ports:
//   CLK        in   system clock, rising edge
//   Reset      in   synchronous active-high reset, overrides everything
//   PCWre      in   PC write enable (0 = stall)
//   PCSrc      in   next-PC select: 00 seq, 01 branch, 10 jump, 11 jump-register
//   immediate  in   signed branch offset in words
//   jaddr      in   jump target field
//   rs_data    in   jump-register target
//   op         in   opcode of the instruction at IAddr
//   IAddr      out  current PC (byte address)
//   PC4        out  IAddr + 4
//   halted     out  sticky halt flag
//   fault      out  sticky illegal-target flag
//   retired    out  completed-instruction count (wraps)
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 64,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] immediate,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs_data,
  input  logic [5:0]  op,
  output logic [31:0] IAddr,
  output logic [31:0] PC4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  // Memory must hold at least one whole, word-aligned instruction.
  if (IMEM_BYTES < 4 || (IMEM_BYTES % 4) != 0) begin : g_param_chk
    $error("pc_unit: IMEM_BYTES must be a positive multiple of 4");
  end

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e      state_q;
  logic [31:0] iaddr_q;
  logic [31:0] retired_q;
  logic        halted_q;
  logic        fault_q;

  logic [31:0] seq_pc;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] target_d;
  logic        misaligned;
  logic        out_of_bounds;

  always_comb begin
    seq_pc    = iaddr_q + 32'd4;
    branch_pc = seq_pc + {{14{immediate[15]}}, immediate, 2'b00};
    jump_pc   = {seq_pc[31:28], jaddr, 2'b00};
    target_d  = seq_pc;
    unique case (PCSrc)
      2'b00:   target_d = seq_pc;
      2'b01:   target_d = branch_pc;
      2'b10:   target_d = jump_pc;
      2'b11:   target_d = rs_data;
      default: target_d = seq_pc;
    endcase
  end

  assign misaligned = |target_d[1:0];

`ifdef PC_BOUNDS_CHECK_EN
  localparam logic [31:0] LastWordAddr = 32'(IMEM_BYTES - 4);
  assign out_of_bounds = (target_d > LastWordAddr);
`else
  assign out_of_bounds = 1'b0;
`endif

  // Halt takes priority over fault; both are absorbing until Reset.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= StRun;
      iaddr_q   <= RESET_PC;
      retired_q <= 32'd0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (PCWre) begin
            if (op == HALT_OP) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else if (misaligned || out_of_bounds) begin
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              iaddr_q   <= target_d;
              retired_q <= retired_q + 32'd1;
            end
          end
        end
        StHalt, StFault: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= StFault;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign IAddr   = iaddr_q;
  assign PC4     = iaddr_q + 32'd4;
  assign halted  = halted_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes hand-computed expectations
// after each rising edge; a monitor pops and compares them on the falling edge.
module tb_pc_unit;

  localparam logic [5:0] Halt = 6'b111111;

  logic        CLK;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [15:0] immediate;
  logic [25:0] jaddr;
  logic [31:0] rs_data;
  logic [5:0]  op;
  logic [31:0] IAddr;
  logic [31:0] PC4;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  pc_unit #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(64),
    .HALT_OP   (Halt)
  ) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .PCWre    (PCWre),
    .PCSrc    (PCSrc),
    .immediate(immediate),
    .jaddr    (jaddr),
    .rs_data  (rs_data),
    .op       (op),
    .IAddr    (IAddr),
    .PC4      (PC4),
    .halted   (halted),
    .fault    (fault),
    .retired  (retired)
  );

  typedef struct {
    string       name;
    logic [31:0] iaddr;
    logic        halted;
    logic        fault;
    logic [31:0] retired;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Monitor: compares every expectation the driver queued.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 5;
      if (IAddr !== e.iaddr) begin
        errors++;
        $display("FAIL %s IAddr: got %h want %h", e.name, IAddr, e.iaddr);
      end
      if (PC4 !== e.iaddr + 32'd4) begin
        errors++;
        $display("FAIL %s PC4: got %h want %h", e.name, PC4, e.iaddr + 32'd4);
      end
      if (halted !== e.halted) begin
        errors++;
        $display("FAIL %s halted: got %b want %b", e.name, halted, e.halted);
      end
      if (fault !== e.fault) begin
        errors++;
        $display("FAIL %s fault: got %b want %b", e.name, fault, e.fault);
      end
      if (retired !== e.retired) begin
        errors++;
        $display("FAIL %s retired: got %h want %h", e.name, retired, e.retired);
      end
    end
  end

  // Drive one cycle of inputs, then queue what the outputs must be after the edge.
  task automatic step(input string name, input logic rst, input logic we,
                      input logic [1:0] src, input logic [15:0] imm,
                      input logic [25:0] ja, input logic [31:0] rs,
                      input logic [5:0] opc, input logic [31:0] e_ia,
                      input logic e_h, input logic e_f, input logic [31:0] e_ret);
    exp_t e;
    Reset     = rst;
    PCWre     = we;
    PCSrc     = src;
    immediate = imm;
    jaddr     = ja;
    rs_data   = rs;
    op        = opc;
    @(posedge CLK);
    e.name    = name;
    e.iaddr   = e_ia;
    e.halted  = e_h;
    e.fault   = e_f;
    e.retired = e_ret;
    exp_q.push_back(e);
    @(negedge CLK);
    #1;
  endtask

  task automatic seq(input string name, input logic [31:0] e_ia, input logic [31:0] e_ret);
    step(name, 1'b0, 1'b1, 2'b00, 16'h0, 26'h0, 32'h0, 6'd0, e_ia, 1'b0, 1'b0, e_ret);
  endtask

  task automatic do_reset(input string name);
    step(name, 1'b1, 1'b1, 2'b01, 16'h0005, 26'h0, 32'h0, 6'd0, 32'h0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    Reset = 1'b1; PCWre = 1'b0; PCSrc = 2'b00; immediate = '0;
    jaddr = '0; rs_data = '0; op = '0;
    #1;

    // Reset state and sequential fetch.
    do_reset("reset");
    seq("seq1", 32'd4, 32'd1);
    seq("seq2", 32'd8, 32'd2);
    seq("seq3", 32'd12, 32'd3);

    // Stall, then halt, then absorbing halt.
    for (int i = 0; i < 4; i++)
      step("stall", 1'b0, 1'b0, 2'b01, 16'h0004, 26'h0, 32'h0, 6'd0, 32'd12, 1'b0, 1'b0, 32'd3);
    step("halt", 1'b0, 1'b1, 2'b00, 16'h0, 26'h0, 32'h0, Halt, 32'd12, 1'b1, 1'b0, 32'd3);
    step("halt_hold1", 1'b0, 1'b1, 2'b10, 16'h0, 26'h3, 32'h0, 6'd0, 32'd12, 1'b1, 1'b0, 32'd3);
    step("halt_hold2", 1'b0, 1'b1, 2'b11, 16'h0, 26'h0, 32'h22, 6'd0, 32'd12, 1'b1, 1'b0, 32'd3);
    do_reset("halt_reset");

    // Branches backward and forward.
    seq("b_seq1", 32'd4, 32'd1);
    seq("b_seq2", 32'd8, 32'd2);
    step("branch_back", 1'b0, 1'b1, 2'b01, 16'hFFFE, 26'h0, 32'h0, 6'd0, 32'd4, 1'b0, 1'b0, 32'd3);
    step("branch_fwd", 1'b0, 1'b1, 2'b01, 16'h0003, 26'h0, 32'h0, 6'd0, 32'd20, 1'b0, 1'b0, 32'd4);

`ifndef PC_BOUNDS_CHECK_EN
    // Jump keeps the upper PC nibble; misaligned jump-register faults.
    step("jreg_far", 1'b0, 1'b1, 2'b11, 16'h0, 26'h0, 32'h1000_0010, 6'd0,
         32'h1000_0010, 1'b0, 1'b0, 32'd5);
    step("jump", 1'b0, 1'b1, 2'b10, 16'h0, 26'h000_0005, 32'h0, 6'd0,
         32'h1000_0014, 1'b0, 1'b0, 32'd6);
    step("jreg_misal", 1'b0, 1'b1, 2'b11, 16'h0, 26'h0, 32'h0000_0022, 6'd0,
         32'h1000_0014, 1'b0, 1'b1, 32'd6);
    step("fault_hold", 1'b0, 1'b1, 2'b00, 16'h0, 26'h0, 32'h0, Halt,
         32'h1000_0014, 1'b0, 1'b1, 32'd6);
`endif
    do_reset("reset2");

    // Halt wins over a simultaneously misaligned target.
    step("halt_over_fault", 1'b0, 1'b1, 2'b11, 16'h0, 26'h0, 32'h2, Halt,
         32'd0, 1'b1, 1'b0, 32'd0);
    do_reset("reset3");

    // End-of-memory boundary.
    step("jreg56", 1'b0, 1'b1, 2'b11, 16'h0, 26'h0, 32'd56, 6'd0, 32'd56, 1'b0, 1'b0, 32'd1);
    seq("seq60", 32'd60, 32'd2);
`ifdef PC_BOUNDS_CHECK_EN
    step("seq64_oob", 1'b0, 1'b1, 2'b00, 16'h0, 26'h0, 32'h0, 6'd0, 32'd60, 1'b0, 1'b1, 32'd2);
`else
    seq("seq64", 32'd64, 32'd3);
`endif
    do_reset("reset4");

    // Retired counter wrap via backdoor preload.
    dut.retired_q = 32'hFFFF_FFFF;
    seq("wrap", 32'd4, 32'd0);
    seq("post_wrap", 32'd8, 32'd1);

    // Reset wins over a branch in the same cycle.
    do_reset("reset_vs_branch");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
